execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 75 +++++++
 tb/tb_execute_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: ID/EX register, ALU/flags/forwarding/stack/jump execution unit, EX/MEM register.
module execute_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [90:0] id_ex_in,
   input  logic [15:0] immediate,
   input  logic [2:0]  flags,
   input  logic [2:0]  flags_from_memory,
   input  logic [15:0] input_port,
   input  logic [31:0] stack_pointer,
   input  logic [1:0]  fwd_sel,
   input  logic [15:0] fwd_data1,
   input  logic [15:0] fwd_data2,
   output logic [75:0] ex_mem_out,
   output logic [31:0] stack_pointer_out,
   output logic        taken_jump,
   output logic        to_pc_selector
);
   logic [90:0] q;
   logic [75:0] ex_d;
   logic        ior, iow, ops, alu, mr, mw, wb, jmp, sp, spop, jwsp, imm, spc, sfl;
   logic [2:0]  alu_op, wba, src_unused;
   logic [1:0]  fd, fgs;
   logic [15:0] d1, d2, a, b, r;
   logic [31:0] pc, data, addr, step;
   logic [16:0] sum;
   logic [2:0]  ff;
   logic        cf, cond;

   always_ff @(posedge clk) begin
      q          <= rst ? '0 : id_ex_in;
      ex_mem_out <= rst ? '0 : ex_d;
   end

   assign {sfl, spc, imm, src_unused, jwsp, pc, fgs, spop, sp, jmp, wb, mw, mr, wba, d2, d1, fd, alu, alu_op, ops, iow, ior} = q;

   assign a = fwd_sel[0] ? fwd_data1 : d1;
   assign b = fwd_sel[1] ? fwd_data2 : imm ? immediate : d2;

   // 17-bit datapath: bit 16 is carry for add/inc and borrow for sub/dec
   always_comb begin
      sum = '0;
      cf  = flags[1];
      case (alu_op)
         3'd0: begin sum = {1'b0, a} + {1'b0, b}; cf = sum[16]; end
         3'd1: begin sum = {1'b0, a} - {1'b0, b}; cf = sum[16]; end
         3'd2: sum = {1'b0, a & b};
         3'd3: sum = {1'b0, a | b};
         3'd4: sum = {1'b0, ~a};
         3'd5: begin sum = {1'b0, a} + 17'd1; cf = sum[16]; end
         3'd6: begin sum = {1'b0, a} - 17'd1; cf = sum[16]; end
         default: sum = {1'b0, b};
      endcase
   end

   assign r = alu ? sum[15:0] : ior ? input_port : fd == 2'b10 ? b : (fd == 2'b01 || iow || ops) ? a : '0;

   assign ff = (sp && spop && sfl) ? flags_from_memory :
               alu ? {r[15], cf, ~|r} :
               {flags[2], fgs == 2'b01 ? 1'b1 : fgs == 2'b10 ? 1'b0 : flags[1], flags[0]};

   assign data = jmp ? {16'b0, a} :
                 (sp && !spop && spc) ? pc :
                 (!sp && (mr || mw)) ? {16'b0, b} : {16'b0, r};

   assign step              = spc ? 32'd2 : 32'd1;
   assign stack_pointer_out = !sp ? stack_pointer : spop ? stack_pointer + step : stack_pointer - step;
   assign addr              = sp ? (spop ? stack_pointer + 32'd1 : stack_pointer) : (mr || mw) ? {16'b0, a} : '0;

   assign cond           = fd == 2'b00 ? 1'b1 : fd == 2'b01 ? flags[0] : fd == 2'b10 ? flags[2] : flags[1];
   assign taken_jump     = jmp & cond;
   assign to_pc_selector = taken_jump;

   assign ex_d = {ff, sfl, spc, jwsp, addr, wb, mw, mr, wba, data};
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized scoreboard bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
   typedef struct {
      logic ior, iow, ops, alu, mr, mw, wb, jmp, sp, spop, jwsp, imm, spc, sfl;
      logic [2:0] alu_op, wba, src;
      logic [1:0] fd, fgs;
      logic [15:0] d1, d2;
      logic [31:0] pc;
   } ins_t;
   typedef struct {
      logic [15:0] immediate, input_port, fd1, fd2;
      logic [2:0]  flags, ffm;
      logic [31:0] spi;
      logic [1:0]  fsel;
   } side_t;
   typedef struct {
      logic [75:0] ex;
      logic [31:0] spo;
      logic        tj;
   } exp_t;
   typedef struct { int due; logic [75:0] ex; } eq_t;
   typedef struct { int due; logic [31:0] spo; logic tj; } cq_t;

   logic        clk = 0, rst;
   logic [90:0] id_ex_in;
   logic [15:0] immediate, input_port, fwd_data1, fwd_data2;
   logic [2:0]  flags, flags_from_memory;
   logic [31:0] stack_pointer, stack_pointer_out;
   logic [1:0]  fwd_sel;
   logic [75:0] ex_mem_out;
   logic        taken_jump, to_pc_selector;

   int   cyc = 0, pass = 0, total = 0;
   eq_t  eq[$];
   cq_t  cq[$];
   eq_t  emon;
   cq_t  cmon;
   ins_t ins[$];
   side_t sides[$];

   execute_stage dut (
      .clk(clk), .rst(rst), .id_ex_in(id_ex_in), .immediate(immediate), .flags(flags),
      .flags_from_memory(flags_from_memory), .input_port(input_port), .stack_pointer(stack_pointer),
      .fwd_sel(fwd_sel), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .ex_mem_out(ex_mem_out),
      .stack_pointer_out(stack_pointer_out), .taken_jump(taken_jump), .to_pc_selector(to_pc_selector)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [75:0] act, logic [75:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [90:0] pack(ins_t x);
      return {x.sfl, x.spc, x.imm, x.src, x.jwsp, x.pc, x.fgs, x.spop, x.sp, x.jmp, x.wb, x.mw, x.mr,
              x.wba, x.d2, x.d1, x.fd, x.alu, x.alu_op, x.ops, x.iow, x.ior};
   endfunction

   function automatic exp_t model(ins_t x, side_t s);
      exp_t e;
      int a, b, r;
      logic cf, cond;
      logic [2:0] f;
      logic [31:0] data, addr, step;
      a = s.fsel[0] ? s.fd1 : x.d1;
      b = s.fsel[1] ? s.fd2 : (x.imm ? s.immediate : x.d2);
      f = s.flags;
      if (x.alu) begin
         cf = s.flags[1];
         case (x.alu_op)
            3'd0: begin r = a + b; cf = r > 65535; end
            3'd1: begin r = a - b; cf = a < b; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~a;
            3'd5: begin r = a + 1; cf = r > 65535; end
            3'd6: begin r = a - 1; cf = a == 0; end
            default: r = b;
         endcase
         r = r & 'hFFFF;
         f = {r >= 32768, cf, r == 0};
      end else begin
         if (x.ior) r = s.input_port;
         else if (x.fd == 2) r = b;
         else if (x.fd == 1 || x.iow || x.ops) r = a;
         else r = 0;
         if (x.fgs == 1) f[1] = 1'b1;
         else if (x.fgs == 2) f[1] = 1'b0;
      end
      if (x.sp && x.spop && x.sfl) f = s.ffm;
      data = r;
      if (x.jmp) data = a;
      else if (x.sp && !x.spop && x.spc) data = x.pc;
      else if (!x.sp && (x.mr || x.mw)) data = b;
      step = x.spc ? 2 : 1;
      e.spo = s.spi;
      addr = 0;
      if (x.sp && x.spop) begin e.spo = s.spi + step; addr = s.spi + 1; end
      else if (x.sp) begin e.spo = s.spi - step; addr = s.spi; end
      else if (x.mr || x.mw) addr = a;
      if (x.fd == 0) cond = 1'b1;
      else if (x.fd == 1) cond = s.flags[0];
      else if (x.fd == 2) cond = s.flags[2];
      else cond = s.flags[1];
      e.tj = x.jmp && cond;
      e.ex = {f, x.sfl, x.spc, x.jwsp, addr, x.wb, x.mw, x.mr, x.wba, data};
      return e;
   endfunction

   function automatic logic [15:0] rv16();
      int k = $urandom_range(0, 4);
      return k == 0 ? 16'h0000 : k == 1 ? 16'hFFFF : k == 2 ? 16'h8000 : 16'($urandom);
   endfunction

   function automatic ins_t rnd_ins();
      ins_t x;
      int cls = $urandom_range(0, 5);
      {x.ior, x.iow, x.ops, x.wb, x.jwsp, x.imm, x.spc, x.sfl} = 8'($urandom);
      x.alu_op = 3'($urandom); x.wba = 3'($urandom); x.src = 3'($urandom);
      x.fd = 2'($urandom); x.fgs = 2'($urandom);
      x.d1 = rv16(); x.d2 = rv16(); x.pc = $urandom;
      x.alu = cls == 0; x.jmp = cls == 5; x.sp = cls == 3 || cls == 4; x.spop = cls == 4;
      x.mr = (cls >= 2 && cls <= 4) ? 1'($urandom) : 1'b0;
      x.mw = cls == 2 ? (!x.mr || 1'($urandom)) : (cls == 3 || cls == 4) ? 1'($urandom) : 1'b0;
      return x;
   endfunction

   function automatic side_t rnd_side();
      side_t s;
      int k = $urandom_range(0, 4);
      s.immediate = rv16(); s.input_port = 16'($urandom); s.fd1 = rv16(); s.fd2 = rv16();
      s.flags = 3'($urandom); s.ffm = 3'($urandom); s.fsel = 2'($urandom);
      s.spi = k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'hFFFF_FFFE : k == 3 ? 32'h1 : $urandom;
      return s;
   endfunction

   task automatic apply(side_t s);
      immediate = s.immediate; input_port = s.input_port; fwd_data1 = s.fd1; fwd_data2 = s.fd2;
      flags = s.flags; flags_from_memory = s.ffm; stack_pointer = s.spi; fwd_sel = s.fsel;
   endtask

   always @(negedge clk) begin
      while (cq.size() > 0 && cq[0].due == cyc) begin
         cmon = cq.pop_front();
         chk("stack_pointer_out", 76'(stack_pointer_out), 76'(cmon.spo));
         chk("taken_jump", 76'(taken_jump), 76'(cmon.tj));
         chk("to_pc_selector", 76'(to_pc_selector), 76'(cmon.tj));
      end
      while (eq.size() > 0 && eq[0].due == cyc) begin
         emon = eq.pop_front();
         chk("ex_mem_out", ex_mem_out, emon.ex);
      end
   end

   initial begin
      ins_t  x0, x;
      side_t s0, s;
      exp_t  e;
      x0 = '{default: '0};
      x0.wb = 1'b1; x0.wba = 3'd7;
      s0 = '{default: '0};
      s0.input_port = 16'd12; s0.spi = 32'd10; s0.immediate = 16'd12;
      rst = 1'b1; id_ex_in = '0; apply(s0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset ex_mem_out", ex_mem_out, 76'd0);
      chk("reset taken_jump", 76'(taken_jump), 76'd0);
      chk("reset to_pc_selector", 76'(to_pc_selector), 76'd0);
      chk("reset stack_pointer_out", 76'(stack_pointer_out), 76'd10);
      @(posedge clk); #1 rst = 1'b0;

      x = x0; x.fd = 2; x.d1 = 10; x.d2 = 127; ins.push_back(x); sides.push_back(s0);
      x = x0; x.alu = 1; x.fd = 3; x.d1 = 7; x.d2 = 8; ins.push_back(x); sides.push_back(s0);
      x.alu_op = 1; x.d1 = 23; x.d2 = 8; ins.push_back(x); sides.push_back(s0);
      x.d1 = 8; x.d2 = 23; ins.push_back(x); sides.push_back(s0);
      x.alu_op = 2; x.d1 = 5; x.d2 = 10; ins.push_back(x); sides.push_back(s0);
      x.alu_op = 0; x.imm = 1; s = s0; s.fsel = 2'b01; s.fd1 = 55; ins.push_back(x); sides.push_back(s);
      x = x0; x.sp = 1; x.spc = 1; x.pc = 15; x.mw = 1; ins.push_back(x); sides.push_back(s0);
      x.spop = 1; x.sfl = 1; x.mw = 0; x.mr = 1; s = s0; s.ffm = 3'b101; ins.push_back(x); sides.push_back(s);
      x = x0; x.jmp = 1; x.fd = 1; x.d1 = 40; s = s0; s.flags = 3'b001; ins.push_back(x); sides.push_back(s);
      ins.push_back(x); sides.push_back(s0);
      for (int i = 0; i < 300; i++) begin
         ins.push_back(rnd_ins());
         sides.push_back(rnd_side());
      end

      for (int i = 0; i <= ins.size(); i++) begin
         id_ex_in = i < ins.size() ? pack(ins[i]) : '0;
         if (i > 0) begin
            apply(sides[i-1]);
            e = model(ins[i-1], sides[i-1]);
            cq.push_back('{cyc, e.spo, e.tj});
            eq.push_back('{cyc + 1, e.ex});
         end
         @(posedge clk); #1;
      end
      apply(s0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("scoreboard drained", 76'(eq.size() + cq.size()), 76'd0);

      @(posedge clk); #1;
      x = x0; x.jmp = 1; x.d1 = 99;
      id_ex_in = pack(x);
      @(posedge clk); #1;
      id_ex_in = '0;
      chk("pre-reset taken_jump", 76'(taken_jump), 76'(model(x, s0).tj));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid reset ex_mem_out", ex_mem_out, 76'd0);
      chk("mid reset taken_jump", 76'(taken_jump), 76'd0);
      chk("mid reset stack_pointer_out", 76'(stack_pointer_out), 76'd10);
      rst = 1'b0;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
